// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the non-restoring divider.
//   div_state_e       : controller states (IDLE, ITER, FIX)
//   DIV_WIDTH_DEFAULT : default operand width
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_nr_step.sv
// div_nr_step -- one combinational non-restoring division step.
//   i_rem  : previous partial remainder (WIDTH+1 bits, two's complement)
//   i_bit  : next dividend bit to shift in
//   i_dvs  : divisor magnitude (WIDTH+1 bits, MSB always 0)
//   o_rem  : new partial remainder
//   o_qbit : quotient bit (1 when the new remainder is non-negative)
// The shifted value may wrap in WIDTH+1 bits, but the post-add/subtract
// remainder always lies in [-dvs, dvs) and is therefore exact.
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] i_rem,
  input  logic           i_bit,
  input  logic [WIDTH:0] i_dvs,
  output logic [WIDTH:0] o_rem,
  output logic           o_qbit
);

  logic [WIDTH:0] w_shift;

  assign w_shift = {i_rem[WIDTH-1:0], i_bit};
  assign o_rem   = i_rem[WIDTH] ? (w_shift + i_dvs) : (w_shift - i_dvs);
  assign o_qbit  = ~o_rem[WIDTH];

endmodule

// File: rtl/div_nr_param.sv
// div_nr_param -- multi-cycle non-restoring integer divider (signed/unsigned).
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   start             : request, accepted only while busy=0
//   is_signed         : operands are two's complement (sampled with start)
//   dividend, divisor : operands (sampled with start)
//   q, r              : quotient / remainder, held from done to next start
//   busy              : operation in progress
//   done              : one-cycle pulse when q/r are written
//   dbz               : divisor was zero (fast-path build only, else 0)
// Optional feature macro: DIV_DBZ_FAST_EN -- a zero divisor skips the
// iteration phase and reports q=all ones, r=dividend, dbz=1.
// Latency: WIDTH+1 cycles from the start edge (2 on the fast path).
module div_nr_param
  import div_pkg::*;
#(
  parameter  int WIDTH = DIV_WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   r_dvs;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_q_alg;
  logic [WIDTH-1:0] w_r_alg;
  logic [WIDTH-1:0] w_q_out;
  logic [WIDTH-1:0] w_r_out;
  logic             w_dbz_start;
  logic             w_fix_go;

  // MIN's magnitude 2^(WIDTH-1) is representable as an unsigned WIDTH-bit value.
  assign w_dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Final remainder is non-negative after correction, so the low WIDTH bits suffice.
  assign w_rem_fix = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_dvs[WIDTH-1:0])
                                  : r_rem[WIDTH-1:0];
  assign w_q_alg   = r_qsign ? -r_quo     : r_quo;
  assign w_r_alg   = r_rsign ? -w_rem_fix : w_rem_fix;

`ifdef DIV_DBZ_FAST_EN
  logic r_dbz;
  logic r_dbz_op;
  logic r_settle;

  assign w_dbz_start = (divisor == '0);
  // Fast path spends one settle cycle in FIX so done lands two cycles after start.
  assign w_fix_go    = ~r_settle;
  // On the fast path r_dvd holds the raw dividend (never shifted).
  assign w_q_out     = r_dbz_op ? '1    : w_q_alg;
  assign w_r_out     = r_dbz_op ? r_dvd : w_r_alg;
  assign dbz         = r_dbz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dbz    <= 1'b0;
      r_dbz_op <= 1'b0;
      r_settle <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_dbz    <= 1'b0;
      r_dbz_op <= w_dbz_start;
      r_settle <= w_dbz_start;
    end else if (r_state == FIX) begin
      r_settle <= 1'b0;
      if (!r_settle) r_dbz <= r_dbz_op;
    end
  end
`else
  assign w_dbz_start = 1'b0;
  assign w_fix_go    = 1'b1;
  assign w_q_out     = w_q_alg;
  assign w_r_out     = w_r_alg;
  assign dbz         = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_qsign <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_rsign <= is_signed & dividend[WIDTH-1];
            r_dvd   <= w_dbz_start ? dividend : w_dvd_abs;
            r_dvs   <= {1'b0, w_dvs_abs};
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= w_dbz_start ? FIX : ITER;
          end
        end
        ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          if (w_fix_go) begin
            r_q     <= w_q_out;
            r_r     <= w_r_out;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = r_busy;
  assign done = r_done;

endmodule
